// File: rtl/rv_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// rv_ctrl_pkg
//
// Shared definitions for the multi-cycle RISC-V control sequencer:
//   - state_t     : sequencer state encoding
//   - op_class_t  : decoded opcode class
//   - OP_*        : 7-bit major opcodes understood by the core
//   - ALUOP_*     : 3-bit ALU op classes consumed by the ALU control block
//   - PC_SRC_*    : next-PC mux selects
//   - SRCA_* / SRCB_* : ALU operand mux selects
//   - exec_next() : state that follows EXEC for a given opcode class
// ----------------------------------------------------------------------------
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_EXEC   = 4'd3,
        ST_MEM_RD = 4'd4,
        ST_MEM_WR = 4'd5,
        ST_WB_ALU = 4'd6,
        ST_WB_MEM = 4'd7,
        ST_BRANCH = 4'd8,
        ST_JUMP   = 4'd9,
        ST_HALT   = 4'd10
    } state_t;

    typedef enum logic [3:0] {
        CLS_R       = 4'd0,
        CLS_I       = 4'd1,
        CLS_LOAD    = 4'd2,
        CLS_STORE   = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_JAL     = 4'd5,
        CLS_LUI     = 4'd6,
        CLS_SYSTEM  = 4'd7,
        CLS_ILLEGAL = 4'd8
    } op_class_t;

    // Major opcodes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // ALU op classes
    localparam logic [2:0] ALUOP_R      = 3'b000;
    localparam logic [2:0] ALUOP_I      = 3'b001;
    localparam logic [2:0] ALUOP_ADD    = 3'b010;
    localparam logic [2:0] ALUOP_STORE  = 3'b011;
    localparam logic [2:0] ALUOP_BRANCH = 3'b100;
    localparam logic [2:0] ALUOP_JUMP   = 3'b101;
    localparam logic [2:0] ALUOP_LUI    = 3'b110;
    localparam logic [2:0] ALUOP_SYSTEM = 3'b111;

    // Next-PC select
    localparam logic [1:0] PC_SRC_PC4    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    // ALU operand selects
    localparam logic       SRCA_PC   = 1'b0;
    localparam logic       SRCA_RS1  = 1'b1;
    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_FOUR = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;

    // Loads and stores continue to the memory port; every other EXEC
    // class writes the ALU result back.
    function automatic state_t exec_next(input op_class_t cls);
        state_t nxt;
        case (cls)
            CLS_LOAD:  nxt = ST_MEM_RD;
            CLS_STORE: nxt = ST_MEM_WR;
            default:   nxt = ST_WB_ALU;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/rv_opcode_class.sv
// ----------------------------------------------------------------------------
// rv_opcode_class
//
// Pure combinational opcode decoder. Maps the instruction-register opcode
// field onto an opcode class, the ALU op class used in EXEC, and a legal flag.
//
// Ports:
//   i_opcode  in  7   opcode field of the instruction register
//   o_class   out     decoded op_class_t (CLS_ILLEGAL for unknown opcodes)
//   o_alu_op  out 3   ALU op class for this opcode
//   o_legal   out 1   opcode is one the core implements
// ----------------------------------------------------------------------------
module rv_opcode_class
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output op_class_t  o_class,
    output logic [2:0] o_alu_op,
    output logic       o_legal
);

    always_comb begin
        o_class  = CLS_ILLEGAL;
        o_alu_op = ALUOP_R;
        o_legal  = 1'b1;
        case (i_opcode)
            OP_R: begin
                o_class  = CLS_R;
                o_alu_op = ALUOP_R;
            end
            OP_I: begin
                o_class  = CLS_I;
                o_alu_op = ALUOP_I;
            end
            OP_LOAD: begin
                o_class  = CLS_LOAD;
                o_alu_op = ALUOP_ADD;
            end
            OP_STORE: begin
                o_class  = CLS_STORE;
                o_alu_op = ALUOP_STORE;
            end
            OP_BRANCH: begin
                o_class  = CLS_BRANCH;
                o_alu_op = ALUOP_BRANCH;
            end
            OP_JAL: begin
                o_class  = CLS_JAL;
                o_alu_op = ALUOP_JUMP;
            end
            OP_LUI: begin
                o_class  = CLS_LUI;
                o_alu_op = ALUOP_LUI;
            end
            OP_SYSTEM: begin
                o_class  = CLS_SYSTEM;
                o_alu_op = ALUOP_SYSTEM;
            end
            default: begin
                o_class  = CLS_ILLEGAL;
                o_alu_op = ALUOP_R;
                o_legal  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// rv_multicycle_ctrl
//
// Multi-cycle control sequencer. Steps a shared datapath (one ALU, one
// unified memory port) through FETCH, DECODE, EXEC, MEM and WB states and
// drives the per-state datapath enables. ecall/ebreak halt the core until
// reset.
//
// Memory handshake: mem_req is held high for as long as the sequencer needs
// the memory port; a transfer completes in any cycle where mem_req and
// mem_ready are both high. mem_ready is ignored while mem_req is low, and a
// request in flight is simply dropped by reset.
//
// Optional feature (macro RV_MC_PERF_EN): retired-instruction and memory
// stall counters. When the macro is undefined both counter ports are
// constant 0 and no counter flops are built.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   opcode     in 7  instruction-register opcode (stable from DECODE on)
//   br_cond    in 1  ALU branch-condition result, used in BRANCH
//   mem_ready  in 1  memory completes the current request
//   mem_req, mem_we, iord            memory request controls
//   ir_write, pc_write, pc_src       instruction register / PC controls
//   alu_src_a, alu_src_b, alu_op     ALU operand selects and op class
//   reg_write, mem_to_reg            register-file writeback controls
//   halted     out 1 sticky halt indication
//   illegal    out 1 one-cycle pulse in DECODE on an undefined opcode
//   instret    out CNT_W retired-instruction count
//   stall_cyc  out CNT_W memory wait-cycle count
// ----------------------------------------------------------------------------
module rv_multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             br_cond,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instret,
    output logic [CNT_W-1:0] stall_cyc
);

    state_t     r_state;
    state_t     w_next;
    op_class_t  w_class;
    logic [2:0] w_alu_op;
    logic       w_legal;

    rv_opcode_class u_opcode_class (
        .i_opcode (opcode),
        .o_class  (w_class),
        .o_alu_op (w_alu_op),
        .o_legal  (w_legal)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and datapath controls
    // ------------------------------------------------------------------
    always_comb begin
        w_next     = r_state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_PC4;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_R;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        halted     = 1'b0;
        illegal    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_next = ST_FETCH;
            end

            // Instruction read from PC while the ALU forms PC+4.
            ST_FETCH: begin
                mem_req   = 1'b1;
                iord      = 1'b0;
                alu_src_a = SRCA_PC;
                alu_src_b = SRCB_FOUR;
                alu_op    = ALUOP_ADD;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PC_SRC_PC4;
                    w_next   = ST_DECODE;
                end
            end

            // The ALU precomputes PC+imm so BRANCH can use it as target.
            ST_DECODE: begin
                alu_src_a = SRCA_PC;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_BRANCH;
                if (!w_legal) begin
                    illegal = 1'b1;
                    w_next  = ST_FETCH;
                end else begin
                    case (w_class)
                        CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_LUI:
                                    w_next = ST_EXEC;
                        CLS_BRANCH: w_next = ST_BRANCH;
                        CLS_JAL:    w_next = ST_JUMP;
                        CLS_SYSTEM: w_next = ST_HALT;
                        default:    w_next = ST_FETCH;
                    endcase
                end
            end

            ST_EXEC: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = (w_class == CLS_R) ? SRCB_RS2 : SRCB_IMM;
                alu_op    = w_alu_op;
                w_next    = exec_next(w_class);
            end

            ST_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    w_next = ST_WB_MEM;
                end
            end

            ST_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    w_next = ST_FETCH;
                end
            end

            ST_WB_ALU: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b0;
                w_next     = ST_FETCH;
            end

            ST_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                w_next     = ST_FETCH;
            end

            // Compare rs1/rs2; the PC only moves when the condition holds.
            ST_BRANCH: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_BRANCH;
                pc_src    = PC_SRC_BRANCH;
                pc_write  = br_cond;
                w_next    = ST_FETCH;
            end

            // rd <- PC+4 (already in the PC from FETCH) while PC <- target.
            ST_JUMP: begin
                pc_src     = PC_SRC_JUMP;
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                mem_to_reg = 1'b0;
                w_next     = ST_FETCH;
            end

            ST_HALT: begin
                halted = 1'b1;
                w_next = ST_HALT;
            end

            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef RV_MC_PERF_EN
    logic [CNT_W-1:0] r_instret;
    logic [CNT_W-1:0] r_stall_cyc;
    logic             w_retire;
    logic             w_stall;

    // Retirement happens on the last cycle of each instruction; a system
    // instruction retires as the sequencer enters HALT.
    always_comb begin
        w_retire = 1'b0;
        case (r_state)
            ST_WB_ALU, ST_WB_MEM, ST_BRANCH, ST_JUMP: w_retire = 1'b1;
            ST_MEM_WR: w_retire = mem_ready;
            ST_DECODE: w_retire = w_legal && (w_class == CLS_SYSTEM);
            default:   w_retire = 1'b0;
        endcase
    end

    assign w_stall = mem_req && !mem_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_instret   <= '0;
            r_stall_cyc <= '0;
        end else begin
            if (w_retire) begin
                r_instret <= r_instret + CNT_W'(1);
            end
            if (w_stall) begin
                r_stall_cyc <= r_stall_cyc + CNT_W'(1);
            end
        end
    end

    assign instret   = r_instret;
    assign stall_cyc = r_stall_cyc;
`else
    assign instret   = '0;
    assign stall_cyc = '0;
`endif

endmodule

// File: doc/rv_multicycle_ctrl.md
# rv_multicycle_ctrl

Multi-cycle control sequencer for the RISC-V core. It steps one shared datapath (single ALU, single unified memory port) through fetch, decode, execute, memory and writeback. It drives per-state datapath enables and the 3-bit ALUOp consumed by the existing ALU control, and it waits on a req/ready memory handshake. Execution of `ecall`/`ebreak` halts the core until reset.

## Interface
Parameters:
- `CNT_W`, 32, width of performance counters.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset. Synchronous, active-low.
- `opcode`  in  7  instruction-register opcode field; stable from DECODE until the next fetch completes.
- `br_cond`  in  1  ALU branch-condition result, valid in BRANCH.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  write request (store).
- `iord`  out  1  memory address select: 0 = PC, 1 = ALU result register.
- `ir_write`  out  1  load instruction register.
- `pc_write`  out  1  PC update enable (already qualified by `br_cond` for branches).
- `pc_src`  out  2  next-PC select: 0 = PC+4, 1 = branch target, 2 = jump target.
- `alu_src_a`  out  1  ALU A select: 0 = PC, 1 = rs1.
- `alu_src_b`  out  2  ALU B select: 0 = rs2, 1 = constant 4, 2 = immediate.
- `alu_op`  out  3  ALU op class. Encoding: 000 R, 001 I, 010 load/add, 011 store, 100 branch, 101 jump, 110 lui, 111 system.
- `reg_write`  out  1  register-file write enable.
- `mem_to_reg`  out  1  writeback select: 1 = memory data.
- `halted`  out  1  core halted (sticky).
- `illegal`  out  1  one-cycle pulse on an undefined opcode.
- `instret`  out  `CNT_W`  retired-instruction count.
- `stall_cyc`  out  `CNT_W`  memory wait-cycle count.

## Operation
- States:
  - IDLE: reset state; one cycle, then goes to FETCH.
  - FETCH: `mem_req=1`, `iord=0`, `alu_src_a=0`, `alu_src_b=1`, `alu_op=010`. When `mem_ready=1`: `ir_write=1`, `pc_write=1`, `pc_src=0`, go to DECODE. Otherwise hold.
  - DECODE: `alu_src_a=0`, `alu_src_b=2`, `alu_op=100` (precompute target). Dispatch:
    - 0110011, 0010011, 0000011, 0100011, 0110111 → EXEC
    - 1100011 → BRANCH
    - 1101111 → JUMP
    - 1110011 → HALT
    - any other opcode → FETCH with `illegal=1`
  - EXEC: `alu_src_a=1`. `alu_src_b` is 0 for R-type, otherwise 2. `alu_op` per the opcode class. Next state: load → MEM_RD, store → MEM_WR, otherwise → WB_ALU.
  - MEM_RD: `mem_req=1`, `iord=1`. Hold until `mem_ready`, then go to WB_MEM.
  - MEM_WR: `mem_req=1`, `mem_we=1`, `iord=1`. Hold until `mem_ready`, then go to FETCH.
  - WB_ALU: `reg_write=1`, `mem_to_reg=0`, then go to FETCH.
  - WB_MEM: `reg_write=1`, `mem_to_reg=1`, then go to FETCH.
  - BRANCH: `alu_src_a=1`, `alu_src_b=0`, `alu_op=100`, `pc_src=1`, `pc_write=br_cond`, then go to FETCH.
  - JUMP: `pc_src=2`, `pc_write=1`, `reg_write=1`, `mem_to_reg=0` (rd ← PC+4), then go to FETCH.
  - HALT: `halted=1`, all other outputs 0; stays in HALT until reset.
- Outputs not listed for a state are 0.
- `mem_ready` is ignored in any state where `mem_req=0`.
- An instruction retires on the cycle it leaves WB_ALU, WB_MEM, MEM_WR, BRANCH or JUMP, and on entry to HALT.
- An illegal opcode does not retire. `illegal` pulses for exactly one cycle (the DECODE cycle).

## Timing
- Outputs are a combinational decode of the state register plus `mem_ready`/`br_cond` qualification. There are no registered-output delays.
- Cycle counts with zero-wait memory (`mem_ready` high in the request cycle):
  - branch, jal: 3
  - R, I, lui, store: 4
  - load: 5
  - each wait cycle adds 1
- Reset:
  - The state is IDLE on the first edge at which `rst_n=0` is sampled.
  - Every output is 0 while in IDLE, including both counters.
  - The first `mem_req` occurs 1 cycle after `rst_n` is first sampled high.
- Reset mid-request: the request is abandoned (`mem_req` drops after the reset edge). Memory must accept abandonment.

## Configuration
- `RV_MC_PERF_EN` defined:
  - `instret` increments by 1 per retirement.
  - `stall_cyc` increments each cycle with `mem_req=1 && mem_ready=0`.
  - Both wrap modulo 2^`CNT_W` and clear on reset.
- Undefined: both counter ports are tied to constant 0 and no counter flops exist.

## Structure
- Shared package `rv_ctrl_pkg`:
  - state enum
  - opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI, OP_SYSTEM)
  - ALUOp encodings
  - `pc_src`/`alu_src_b` select encodings
- One sub-module, `rv_opcode_class`: pure opcode → {class, `alu_op`, legal} decode, used in DECODE and EXEC.

## Test plan
- R-type `0110011`, `mem_ready` tied 1 → states F, D, E, WB_ALU. `reg_write=1` only in cycle 4. `instret` 0→1.
- Load `0000011`, `mem_ready` low for 2 cycles in MEM_RD → 7 cycles total. `mem_to_reg=1` with `reg_write` in the last cycle. `stall_cyc=2`.
- Branch with `br_cond=0`, then `br_cond=1` → 3 cycles each. `pc_write` is 0 then 1 in BRANCH, with `pc_src=1`.
- Opcode `0000000` → `illegal` pulses once, returns to FETCH, `instret` unchanged. `1110011` → `halted=1` held for 20 cycles with no `mem_req`.
- Assert `rst_n=0` during MEM_WR wait → next cycle IDLE, all outputs 0. Release → `mem_req` 1 cycle later with `iord=0`.
